// File: rtl/exec_dispatch.sv
// exec_dispatch: sequential IDLE->ISSUE->WAIT->WB dispatcher between decoder/register file and ALU.
// Optional ALU watchdog enabled by defining ALU_TIMEOUT_EN.
package exec_dispatch_pkg;

    typedef struct packed {
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        sw;
        logic [3:0]  alu_op;
        logic [31:0] pc;
        logic [31:0] imm;
    } instructions_t;

endpackage

module exec_dispatch
    import exec_dispatch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          dec_valid,
    output logic          dec_ready,
    input  instructions_t dec_instr,
    input  logic [4:0]    dec_rs1_idx,
    input  logic [4:0]    dec_rs2_idx,
    input  logic [4:0]    dec_rd_idx,
    input  logic          dec_wb_en,
    output logic [4:0]    rf_rs1_idx,
    output logic [4:0]    rf_rs2_idx,
    input  logic [31:0]   rf_rs1_data,
    input  logic [31:0]   rf_rs2_data,
    output logic          alu_enabled,
    output instructions_t alu_instr,
    output logic [31:0]   alu_rs1,
    output logic [31:0]   alu_rs2,
    input  logic          alu_completed,
    input  logic [31:0]   alu_rd,
    output logic          rf_we,
    output logic [4:0]    rf_wr_idx,
    output logic [31:0]   rf_wr_data,
    output logic          pc_valid,
    output logic [31:0]   pc_next,
    output logic          busy,
    output logic          err_timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    instructions_t instr_q;
    logic [4:0]    rs1_idx_q;
    logic [4:0]    rs2_idx_q;
    logic [4:0]    rd_idx_q;
    logic          wb_en_q;
    logic [31:0]   rs1_q;
    logic [31:0]   rs2_q;
    logic [31:0]   res_q;
    logic          accept;
    logic          timeout_hit;
    logic          timed_out_q;

    assign accept = (state == S_IDLE) && dec_valid;

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign timeout_hit = (state == S_WAIT) && !alu_completed &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt    <= '0;
            timed_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (state == S_ISSUE)
                wait_cnt <= '0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            // Per-instruction abort marker; the error flag itself stays until reset.
            if (accept)
                timed_out_q <= 1'b0;
            else if (timeout_hit)
                timed_out_q <= 1'b1;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign timed_out_q = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (dec_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (alu_completed || timeout_hit) state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            instr_q   <= '0;
            rs1_idx_q <= '0;
            rs2_idx_q <= '0;
            rd_idx_q  <= '0;
            wb_en_q   <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            res_q     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                instr_q   <= dec_instr;
                rs1_idx_q <= dec_rs1_idx;
                rs2_idx_q <= dec_rs2_idx;
                rd_idx_q  <= dec_rd_idx;
                wb_en_q   <= dec_wb_en;
                rs1_q     <= rf_rs1_data;
                rs2_q     <= rf_rs2_data;
            end
            if ((state == S_WAIT) && alu_completed)
                res_q <= alu_rd;
        end
    end

    // Operands are read combinationally in IDLE, so the indices follow the decoder there.
    assign rf_rs1_idx = (state == S_IDLE) ? dec_rs1_idx : rs1_idx_q;
    assign rf_rs2_idx = (state == S_IDLE) ? dec_rs2_idx : rs2_idx_q;

    assign dec_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign alu_enabled = (state == S_ISSUE);
    assign alu_instr   = instr_q;
    assign alu_rs1     = rs1_q;
    assign alu_rs2     = rs2_q;

    assign rf_we      = (state == S_WB) && wb_en_q && (rd_idx_q != 5'd0) &&
                        !(instr_q.branch || instr_q.sw) && !timed_out_q;
    assign rf_wr_idx  = rd_idx_q;
    assign rf_wr_data = res_q;
    assign pc_valid   = (state == S_WB);

    logic [31:0] pc_seq;
    logic [31:0] pc_rel;
    logic [31:0] pc_jalr;
    logic [31:0] jalr_sum;
    logic [31:0] pc_calc;

    assign pc_seq   = instr_q.pc + 32'd1;
    assign pc_rel   = instr_q.pc + 32'($signed(instr_q.imm) >>> 2);
    assign jalr_sum = rs1_q + instr_q.imm;
    assign pc_jalr  = 32'($signed(jalr_sum) >>> 2);

    always_comb begin
        pc_calc = pc_seq;
        if (timed_out_q)
            pc_calc = pc_seq;
        else if (instr_q.branch && res_q[0])
            pc_calc = pc_rel;
        else if (instr_q.jal)
            pc_calc = pc_rel;
        else if (instr_q.jalr)
            pc_calc = pc_jalr;
    end

    // Gated so the bus reads zero whenever no target is being reported.
    assign pc_next = (state == S_WB) ? pc_calc : 32'd0;

endmodule

// File: tb/tb_exec_dispatch.sv
// Directed self-checking bench for exec_dispatch; timeout scenario runs when ALU_TIMEOUT_EN is defined.
module tb_exec_dispatch;
    import exec_dispatch_pkg::*;

    logic          clk = 1'b0;
    logic          rstn;
    logic          dec_valid;
    logic          dec_ready;
    instructions_t dec_instr;
    logic [4:0]    dec_rs1_idx, dec_rs2_idx, dec_rd_idx;
    logic          dec_wb_en;
    logic [4:0]    rf_rs1_idx, rf_rs2_idx;
    logic [31:0]   rf_rs1_data, rf_rs2_data;
    logic          alu_enabled;
    instructions_t alu_instr;
    logic [31:0]   alu_rs1, alu_rs2;
    logic          alu_completed;
    logic [31:0]   alu_rd;
    logic          rf_we;
    logic [4:0]    rf_wr_idx;
    logic [31:0]   rf_wr_data;
    logic          pc_valid;
    logic [31:0]   pc_next;
    logic          busy;
    logic          err_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exec_dispatch #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rstn(rstn),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
        .dec_rs1_idx(dec_rs1_idx), .dec_rs2_idx(dec_rs2_idx), .dec_rd_idx(dec_rd_idx),
        .dec_wb_en(dec_wb_en),
        .rf_rs1_idx(rf_rs1_idx), .rf_rs2_idx(rf_rs2_idx),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .alu_enabled(alu_enabled), .alu_instr(alu_instr), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_completed(alu_completed), .alu_rd(alu_rd),
        .rf_we(rf_we), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
        .pc_valid(pc_valid), .pc_next(pc_next), .busy(busy), .err_timeout(err_timeout)
    );

    function automatic instructions_t mk(input logic br, input logic jl, input logic jr,
                                         input logic s, input logic [31:0] pc,
                                         input logic [31:0] imm);
        instructions_t i;
        i.branch = br; i.jal = jl; i.jalr = jr; i.sw = s;
        i.alu_op = 4'h3; i.pc = pc; i.imm = imm;
        return i;
    endfunction

    task automatic idle_inputs();
        dec_valid = 1'b0; dec_instr = '0; dec_rs1_idx = '0; dec_rs2_idx = '0;
        dec_rd_idx = '0; dec_wb_en = 1'b0; rf_rs1_data = '0; rf_rs2_data = '0;
        alu_completed = 1'b0; alu_rd = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if (dec_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_ready: ready=%b busy=%b want 1/0", dec_ready, busy);
        end
        total++;
        if ({alu_enabled, rf_we, pc_valid, err_timeout} !== 4'b0 || alu_rs1 !== 0 ||
            alu_rs2 !== 0 || alu_instr !== '0 || rf_wr_data !== 0 || rf_wr_idx !== 0 || pc_next !== 0) begin
            bad++; $display("FAIL reset_outputs: en=%b we=%b pv=%b rs1=%h pc=%h want all 0",
                            alu_enabled, rf_we, pc_valid, alu_rs1, pc_next);
        end
    endtask

    // Runs one instruction through the four-cycle sequence, checking each cycle.
    task automatic run_instr(input string nm, input instructions_t ins,
                             input logic [4:0] rs1i, input logic [4:0] rs2i, input logic [4:0] rdi,
                             input logic wb, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] res, input logic exp_we, input logic [31:0] exp_pc);
        // cycle 0: offer
        dec_valid = 1'b1; dec_instr = ins; dec_rs1_idx = rs1i; dec_rs2_idx = rs2i;
        dec_rd_idx = rdi; dec_wb_en = wb; rf_rs1_data = d1; rf_rs2_data = d2;
        #1;
        total++;
        if (dec_ready !== 1'b1 || rf_rs1_idx !== rs1i || rf_rs2_idx !== rs2i) begin
            bad++; $display("FAIL %s_c0: ready=%b idx=%0d/%0d want 1 %0d/%0d",
                            nm, dec_ready, rf_rs1_idx, rf_rs2_idx, rs1i, rs2i);
        end
        @(negedge clk);
        // cycle 1: issue; scramble decoder inputs to prove latching
        dec_valid = 1'b0; dec_rs1_idx = ~rs1i; dec_rs2_idx = ~rs2i; rf_rs1_data = ~d1;
        #1;
        total++;
        if (alu_enabled !== 1'b1 || alu_rs1 !== d1 || alu_rs2 !== d2 || alu_instr !== ins ||
            rf_rs1_idx !== rs1i || busy !== 1'b1 || dec_ready !== 1'b0) begin
            bad++; $display("FAIL %s_c1: en=%b rs1=%h rs2=%h idx=%0d busy=%b want 1 %h %h %0d 1",
                            nm, alu_enabled, alu_rs1, alu_rs2, rf_rs1_idx, busy, d1, d2, rs1i);
        end
        alu_completed = 1'b1; alu_rd = res;
        @(negedge clk);
        // cycle 2: wait, result sampled at the next edge
        total++;
        if (alu_enabled !== 1'b0 || rf_we !== 1'b0 || pc_valid !== 1'b0) begin
            bad++; $display("FAIL %s_c2: en=%b we=%b pv=%b want 0 0 0", nm, alu_enabled, rf_we, pc_valid);
        end
        @(negedge clk);
        // cycle 3: writeback
        alu_rd = ~res;
        #1;
        total++;
        if (rf_we !== exp_we || pc_valid !== 1'b1 || pc_next !== exp_pc) begin
            bad++; $display("FAIL %s_c3: we=%b pv=%b pc=%h want %b 1 %h",
                            nm, rf_we, pc_valid, pc_next, exp_we, exp_pc);
        end
        if (exp_we) begin
            total++;
            if (rf_wr_idx !== rdi || rf_wr_data !== res) begin
                bad++; $display("FAIL %s_wr: idx=%0d data=%h want %0d %h", nm, rf_wr_idx, rf_wr_data, rdi, res);
            end
        end
        alu_completed = 1'b0;
        @(negedge clk);
        // cycle 4: back in IDLE
        total++;
        if (pc_valid !== 1'b0 || rf_we !== 1'b0 || dec_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL %s_c4: pv=%b we=%b ready=%b busy=%b want 0 0 1 0",
                            nm, pc_valid, rf_we, dec_ready, busy);
        end
        idle_inputs();
    endtask

    task automatic test_alu_ops();
        run_instr("addi", mk(0,0,0,0, 32'h20, 32'd7), 5'd0, 5'd0, 5'd5, 1'b1, 0, 0, 32'd7, 1'b1, 32'h21);
        run_instr("beq_taken", mk(1,0,0,0, 32'h10, 32'd8), 5'd2, 5'd3, 5'd0, 1'b0,
                  32'h5, 32'h5, 32'd1, 1'b0, 32'h12);
        run_instr("beq_not", mk(1,0,0,0, 32'h10, 32'd8), 5'd2, 5'd3, 5'd7, 1'b1,
                  32'h5, 32'h6, 32'd0, 1'b0, 32'h11);
        run_instr("jalr", mk(0,0,1,0, 32'h30, 32'hFFFF_FFFC), 5'd3, 5'd0, 5'd1, 1'b1,
                  32'h100, 0, 32'h31, 1'b1, 32'h3F);
        run_instr("jal_neg", mk(0,1,0,0, 32'h40, 32'hFFFF_FFF8), 5'd0, 5'd0, 5'd1, 1'b1,
                  0, 0, 32'h41, 1'b1, 32'h3E);
        run_instr("sw", mk(0,0,0,1, 32'h50, 32'd4), 5'd4, 5'd6, 5'd5, 1'b1,
                  32'h200, 32'hAB, 32'h204, 1'b0, 32'h51);
        run_instr("add_rd0", mk(0,0,0,0, 32'h60, 32'd0), 5'd1, 5'd2, 5'd0, 1'b1,
                  32'd3, 32'd4, 32'd7, 1'b0, 32'h61);
        run_instr("pc_wrap", mk(0,0,0,0, 32'hFFFF_FFFF, 32'd0), 5'd1, 5'd2, 5'd9, 1'b1,
                  32'd3, 32'd4, 32'hDEAD_BEEF, 1'b1, 32'h0);
    endtask

    task automatic test_back_to_back();
        int acc_cycle;
        acc_cycle = -1;
        dec_valid = 1'b1; dec_instr = mk(0,0,0,0, 32'h70, 32'd1); dec_rd_idx = 5'd2;
        dec_wb_en = 1'b1; alu_completed = 1'b1; alu_rd = 32'h11;
        // Decoder holds valid; the second accept must land on cycle 4.
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c >= 1 && dec_ready === 1'b1 && acc_cycle < 0) acc_cycle = c;
            @(negedge clk);
        end
        total++;
        if (acc_cycle !== 4) begin
            bad++; $display("FAIL b2b_accept: second accept at cycle %0d want 4", acc_cycle);
        end
        idle_inputs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int seen_wb;
        seen_wb = 0;
        dec_valid = 1'b1; dec_instr = mk(0,0,0,0, 32'h80, 32'd3); dec_rd_idx = 5'd4;
        dec_wb_en = 1'b1; rf_rs1_data = 32'h1234; alu_completed = 1'b0;
        @(negedge clk);
        dec_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);   // in WAIT
        rstn = 1'b0;
        #1;
        total++;
        if ({alu_enabled, rf_we, pc_valid, busy, err_timeout} !== 5'b0 || alu_rs1 !== 0 ||
            alu_instr !== '0 || pc_next !== 0 || rf_wr_idx !== 0 || dec_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid: en=%b we=%b pv=%b busy=%b rs1=%h ready=%b want 0 0 0 0 0 1",
                            alu_enabled, rf_we, pc_valid, busy, alu_rs1, dec_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        alu_completed = 1'b1; alu_rd = 32'h55;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (rf_we === 1'b1 || pc_valid === 1'b1) seen_wb++;
            @(negedge clk);
        end
        total++;
        if (seen_wb !== 0 || busy !== 1'b0 || dec_ready !== 1'b1) begin
            bad++; $display("FAIL rst_abort: wb_events=%0d busy=%b ready=%b want 0 0 1", seen_wb, busy, dec_ready);
        end
        idle_inputs();
    endtask

`ifdef ALU_TIMEOUT_EN
    task automatic test_timeout();
        int wb_cycle;
        logic we_seen;
        logic [31:0] pc_seen;
        wb_cycle = -1; we_seen = 1'b0; pc_seen = '0;
        dec_valid = 1'b1; dec_instr = mk(0,0,0,0, 32'h90, 32'd5); dec_rd_idx = 5'd6;
        dec_wb_en = 1'b1; alu_completed = 1'b0;
        @(negedge clk);
        dec_valid = 1'b0;
        for (int c = 1; c < 40 && wb_cycle < 0; c++) begin
            #1;
            if (pc_valid === 1'b1) begin wb_cycle = c; we_seen = rf_we; pc_seen = pc_next; end
            @(negedge clk);
        end
        total++;
        if (wb_cycle !== 18 || we_seen !== 1'b0 || pc_seen !== 32'h91) begin
            bad++; $display("FAIL timeout_wb: wb cycle=%0d we=%b pc=%h want 18 0 00000091",
                            wb_cycle, we_seen, pc_seen);
        end
        repeat (2) @(negedge clk);
        total++;
        if (err_timeout !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL timeout_sticky: err=%b busy=%b want 1 0", err_timeout, busy);
        end
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_alu_ops();
        test_back_to_back();
        test_reset_mid_op();
`ifdef ALU_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
